// File: rtl/bit_framer.sv
// rtl/bit_framer.sv - byte-to-serial framer: preamble, MSB-first data, even parity, fixed bit period
module bit_framer #(
    parameter int unsigned BIT_CLKS = 60,
    parameter int unsigned PRE_LEN  = 8,
    parameter logic [15:0] PREAMBLE = 16'hAAAA
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       Data_out,
    output logic       bit_strobe,
    output logic       busy,
    output logic       frame_done
);

    // Preamble left-justified so the first bit to send always sits in bit 15.
    localparam logic [15:0] PRE_ALIGNED = PREAMBLE << (16 - PRE_LEN);
    localparam logic [15:0] TIMER_LAST  = 16'(BIT_CLKS - 1);
    localparam logic [3:0]  PRE_LAST    = 4'(PRE_LEN - 1);
    localparam logic [3:0]  DATA_LAST   = 4'd7;

    typedef enum logic [1:0] {
        IDLE,
        PRE,
        DATA,
        PAR
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] timer;
    logic [3:0]  bit_idx;
    logic [7:0]  data_sr;
    logic [15:0] pre_sr;
    logic        parity;
    logic        bit_last;

    assign bit_last = (timer == TIMER_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and status outputs, all derived from the current state and bit timer.
    always_comb begin
        state_next = state;
        tx_ready   = 1'b0;
        busy       = 1'b1;
        bit_strobe = (timer == 16'd0);
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                tx_ready   = 1'b1;
                busy       = 1'b0;
                bit_strobe = 1'b0;
                if (tx_valid) begin
                    state_next = PRE;
                end
            end
            PRE: begin
                if (bit_last && bit_idx == PRE_LAST) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_last && bit_idx == DATA_LAST) begin
                    state_next = PAR;
                end
            end
            PAR: begin
                frame_done = bit_last;
                if (bit_last) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: latch byte on handshake, then load the next serial bit at each bit-period wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            Data_out <= 1'b0;
            timer    <= 16'd0;
            bit_idx  <= 4'd0;
            data_sr  <= 8'd0;
            pre_sr   <= 16'd0;
            parity   <= 1'b0;
        end else if (state == IDLE) begin
            timer   <= 16'd0;
            bit_idx <= 4'd0;
            if (tx_valid) begin
                data_sr  <= tx_data;
                parity   <= ^tx_data;
                pre_sr   <= {PRE_ALIGNED[14:0], 1'b0};
                Data_out <= PRE_ALIGNED[15];
            end else begin
                Data_out <= 1'b0;
            end
        end else if (!bit_last) begin
            timer <= timer + 16'd1;
        end else begin
            timer <= 16'd0;
            case (state)
                PRE: begin
                    if (bit_idx == PRE_LAST) begin
                        bit_idx  <= 4'd0;
                        Data_out <= data_sr[7];
                        data_sr  <= {data_sr[6:0], 1'b0};
                    end else begin
                        bit_idx  <= bit_idx + 4'd1;
                        Data_out <= pre_sr[15];
                        pre_sr   <= {pre_sr[14:0], 1'b0};
                    end
                end
                DATA: begin
                    if (bit_idx == DATA_LAST) begin
                        bit_idx  <= 4'd0;
                        Data_out <= parity;
                    end else begin
                        bit_idx  <= bit_idx + 4'd1;
                        Data_out <= data_sr[7];
                        data_sr  <= {data_sr[6:0], 1'b0};
                    end
                end
                default: begin
                    bit_idx  <= 4'd0;
                    Data_out <= 1'b0;
                end
            endcase
        end
    end

endmodule
